// File: rtl/cdc_fifo_nibble_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_fifo_nibble_reader_if
// Brief    : FIFO read port and byte output port of the nibble reader.
// Revision : 1.0
// ============================================================================
interface cdc_fifo_nibble_reader_if;
    logic       fifo_empty;
    logic [3:0] fifo_read_data;
    logic       fifo_read_increment;
    logic       flush;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       partial;
    logic [7:0] byte_count;

    // The reader itself.
    modport slave (
        input  fifo_empty,
        input  fifo_read_data,
        input  flush,
        input  byte_ready,
        output fifo_read_increment,
        output byte_data,
        output byte_valid,
        output partial,
        output byte_count
    );

    // The environment: FIFO, control and downstream sink.
    modport master (
        output fifo_empty,
        output fifo_read_data,
        output flush,
        output byte_ready,
        input  fifo_read_increment,
        input  byte_data,
        input  byte_valid,
        input  partial,
        input  byte_count
    );
endinterface
`default_nettype wire

// File: rtl/cdc_fifo_nibble_reader.sv
`default_nettype none
// ============================================================================
// Module   : cdc_fifo_nibble_reader
// Brief    : Pops nibbles from a FWFT FIFO and presents them as bytes on a
//            valid/ready port with backpressure.
// Revision : 1.0
// ============================================================================
module cdc_fifo_nibble_reader #(
    parameter int LOW_FIRST = 1
) (
    input  logic                        read_clock,
    input  logic                        read_reset,
    cdc_fifo_nibble_reader_if.slave     bus
);

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] staging_q;
    logic [7:0] byte_data_q;
    logic       byte_valid_q;
    logic [7:0] byte_count_q;

    logic       w_slot_free;
    logic       w_handshake;
    logic       w_pop;
    logic [7:0] w_assembled;

    generate
        if (LOW_FIRST != 0) begin : g_low_first
            assign w_assembled = {bus.fifo_read_data, staging_q};
        end else begin : g_high_first
            assign w_assembled = {staging_q, bus.fifo_read_data};
        end
    endgenerate

    assign w_slot_free = !byte_valid_q || bus.byte_ready;
    assign w_handshake = byte_valid_q && bus.byte_ready;

    // The first nibble may always be taken; the second only when the output
    // slot can accept the completed byte on this edge.
    assign w_pop = !read_reset && !bus.fifo_empty && !bus.flush &&
                   ((state_q == ST_FIRST) || w_slot_free);

    always_ff @(posedge read_clock) begin
        if (read_reset) begin
            state_q      <= ST_FIRST;
            staging_q    <= 4'h0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_count_q <= 8'h00;
        end else begin
            if (bus.flush) begin
                state_q <= ST_FIRST;
            end else if (w_pop) begin
                if (state_q == ST_FIRST) begin
                    staging_q <= bus.fifo_read_data;
                    state_q   <= ST_SECOND;
                end else begin
                    byte_data_q <= w_assembled;
                    state_q     <= ST_FIRST;
                end
            end

            // A load on the accepting edge refills the slot without a bubble.
            if (w_pop && (state_q == ST_SECOND)) begin
                byte_valid_q <= 1'b1;
            end else if (w_handshake) begin
                byte_valid_q <= 1'b0;
            end

            if (w_handshake) begin
                byte_count_q <= byte_count_q + 8'd1;
            end
        end
    end

    assign bus.fifo_read_increment = w_pop;
    assign bus.byte_data           = byte_data_q;
    assign bus.byte_valid          = byte_valid_q;
    assign bus.partial             = (state_q == ST_SECOND);
    assign bus.byte_count          = byte_count_q;

endmodule
`default_nettype wire
